// File: rtl/axi4_addr_bfm.sv
// axi4_addr_bfm
//   Master-side driver for the AXI4 read-address (AR) and write-address (AW)
//   channels. A proxy pushes packed address commands into a per-channel FIFO;
//   each channel pops its FIFO head into a registered pin stage and presents
//   it with AXI4 VALID/READY semantics. The AR and AW channels are identical
//   and fully independent. They share only clk and rst.
//
//   Parameters
//     ID_W   : width of arid/awid
//     ADDR_W : address width
//     DEPTH  : command FIFO entries per channel (power of two, >= 2)
//
//   Ports (x = ar / aw)
//     clk, rst          : rising-edge clock, asynchronous active-high reset
//     x_req_valid/x_req : packed command offered by the proxy, id at the MSB
//     x_req_ready       : FIFO has room (low during reset)
//     xid .. xregion    : AXI address-channel fields (registered)
//     xvalid / xready   : AXI handshake
//     x_done            : one-cycle pulse after each completed handshake
//     x_idle            : FIFO empty and xvalid low

// One address channel: FIFO plus registered pin stage.
module axi4_addr_chan #(
  parameter int unsigned CMD_W = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [CMD_W-1:0] req_i,
  output logic             req_ready_o,
  output logic [CMD_W-1:0] cmd_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             done_o,
  output logic             idle_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [CMD_W-1:0] cmd_q;
  logic             valid_q;
  logic             done_q;
  logic             push, load;

  // Readiness ignores a same-cycle pop, so a full FIFO never accepts.
  assign req_ready_o = !rst && (count_q < FULL_CNT);
  assign push        = req_valid_i && req_ready_o;
  assign load        = (count_q != '0) && (!valid_q || ready_i);

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; emptying the pointers/count discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= req_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= valid_q && ready_i;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (load) begin
        cmd_q   <= mem_q[rptr_q];
        rptr_q  <= rptr_q + PTR_W'(1);
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        // Drained: fields keep their last values, only VALID drops.
        valid_q <= 1'b0;
      end
    end
  end

  assign cmd_o   = cmd_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign idle_o  = (count_q == '0) && !valid_q;

endmodule

module axi4_addr_bfm #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // AR
  input  logic                       ar_req_valid,
  input  logic [ID_W+ADDR_W+29-1:0]  ar_req,
  output logic                       ar_req_ready,
  output logic [ID_W-1:0]            arid,
  output logic [ADDR_W-1:0]          araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arlock,
  output logic [3:0]                 arcache,
  output logic [2:0]                 arprot,
  output logic [3:0]                 arqos,
  output logic [3:0]                 arregion,
  output logic                       arvalid,
  input  logic                       arready,
  output logic                       ar_done,
  output logic                       ar_idle,
  // AW
  input  logic                       aw_req_valid,
  input  logic [ID_W+ADDR_W+29-1:0]  aw_req,
  output logic                       aw_req_ready,
  output logic [ID_W-1:0]            awid,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot,
  output logic [3:0]                 awqos,
  output logic [3:0]                 awregion,
  output logic                       awvalid,
  input  logic                       awready,
  output logic                       aw_done,
  output logic                       aw_idle
);

  localparam int unsigned CMD_W = ID_W + ADDR_W + 29;

  logic [CMD_W-1:0] ar_cmd, aw_cmd;

  axi4_addr_chan #(.CMD_W(CMD_W), .DEPTH(DEPTH)) u_ar (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(ar_req_valid),
    .req_i      (ar_req),
    .req_ready_o(ar_req_ready),
    .cmd_o      (ar_cmd),
    .valid_o    (arvalid),
    .ready_i    (arready),
    .done_o     (ar_done),
    .idle_o     (ar_idle)
  );

  axi4_addr_chan #(.CMD_W(CMD_W), .DEPTH(DEPTH)) u_aw (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(aw_req_valid),
    .req_i      (aw_req),
    .req_ready_o(aw_req_ready),
    .cmd_o      (aw_cmd),
    .valid_o    (awvalid),
    .ready_i    (awready),
    .done_o     (aw_done),
    .idle_o     (aw_idle)
  );

  assign {arid, araddr, arlen, arsize, arburst, arlock,
          arcache, arprot, arqos, arregion} = ar_cmd;
  assign {awid, awaddr, awlen, awsize, awburst, awlock,
          awcache, awprot, awqos, awregion} = aw_cmd;

endmodule

// File: tb/tb_axi4_addr_bfm.sv
// Directed self-checking bench for axi4_addr_bfm (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_axi4_addr_bfm;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CMD_W  = ID_W + ADDR_W + 29;

  logic clk = 1'b0;
  logic rst;
  logic ar_req_valid, aw_req_valid;
  logic [CMD_W-1:0] ar_req, aw_req;
  logic ar_req_ready, aw_req_ready;
  logic [ID_W-1:0] arid, awid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst;
  logic arlock, awlock;
  logic [3:0] arcache, awcache, arqos, awqos, arregion, awregion;
  logic arvalid, awvalid, arready, awready;
  logic ar_done, aw_done, ar_idle, aw_idle;

  logic [CMD_W-1:0] ar_pins, aw_pins;
  assign ar_pins = {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion};
  assign aw_pins = {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi4_addr_bfm #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ar_req_valid(ar_req_valid), .ar_req(ar_req), .ar_req_ready(ar_req_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .arvalid(arvalid), .arready(arready), .ar_done(ar_done), .ar_idle(ar_idle),
    .aw_req_valid(aw_req_valid), .aw_req(aw_req), .aw_req_ready(aw_req_ready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .awvalid(awvalid), .awready(awready), .aw_done(aw_done), .aw_idle(aw_idle)
  );

  function automatic logic [CMD_W-1:0] mk(
    input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
    input logic [2:0] size, input logic [1:0] burst, input logic lock,
    input logic [3:0] cache, input logic [2:0] prot, input logic [3:0] qos,
    input logic [3:0] region);
    return {id, addr, len, size, burst, lock, cache, prot, qos, region};
  endfunction

  function automatic logic [CMD_W-1:0] b2b_cmd(input int i);
    logic [31:0] iv;
    iv = 32'(i);
    return mk(iv[3:0], 32'h0000_2000 + 32'(i * 4), iv[7:0], 3'd3, 2'd1, iv[0],
              4'hF - iv[3:0], iv[2:0], iv[3:0], 4'h9);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arready = 1'b0; awready = 1'b0;
    ar_req_valid = 1'b1; aw_req_valid = 1'b1;
    ar_req = mk(4'h7, 32'hDEAD_BEEF, 8'h3, 3'd2, 2'd1, 1'b1, 4'h3, 3'd1, 4'h2, 4'h4);
    aw_req = ar_req;
    repeat (3) tick();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got=%0b exp=0", arvalid); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got=%0b exp=0", awvalid); end
    checks++; if (ar_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ar_req_ready got=%0b exp=0", ar_req_ready); end
    checks++; if (aw_req_ready !== 1'b0) begin errors++; $display("FAIL rst_aw_req_ready got=%0b exp=0", aw_req_ready); end
    checks++; if (ar_idle !== 1'b1 || aw_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%0b%0b exp=11", ar_idle, aw_idle); end
    checks++; if (ar_done !== 1'b0 || aw_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b%0b exp=00", ar_done, aw_done); end
    checks++; if (ar_pins !== '0) begin errors++; $display("FAIL rst_ar_fields got=%h exp=0", ar_pins); end
    checks++; if (aw_pins !== '0) begin errors++; $display("FAIL rst_aw_fields got=%h exp=0", aw_pins); end
    ar_req_valid = 1'b0; aw_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (ar_req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ar_req_ready got=%0b exp=1", ar_req_ready); end
    checks++; if (aw_req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_aw_req_ready got=%0b exp=1", aw_req_ready); end
  endtask

  task automatic test_single_read();
    logic [CMD_W-1:0] c;
    c = mk(4'd3, 32'h8000_0000, 8'd0, 3'd2, 2'd1, 1'b0, 4'h0, 3'd0, 4'h0, 4'h0);
    arready = 1'b1;
    ar_req = c; ar_req_valid = 1'b1;
    tick();  // edge N: push
    ar_req_valid = 1'b0;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b exp=0", arvalid); end
    tick();  // edge N+1: load
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", arvalid); end
    checks++; if (ar_pins !== c) begin errors++; $display("FAIL single_fields got=%h exp=%h", ar_pins, c); end
    checks++; if (arid !== 4'd3 || araddr !== 32'h8000_0000 || arsize !== 3'd2 || arburst !== 2'd1)
      begin errors++; $display("FAIL single_id_addr got=%0h/%h exp=3/80000000", arid, araddr); end
    tick();  // handshake
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%0b exp=0", arvalid); end
    checks++; if (ar_done !== 1'b1) begin errors++; $display("FAIL single_done got=%0b exp=1", ar_done); end
    checks++; if (ar_pins !== c) begin errors++; $display("FAIL single_fields_hold got=%h exp=%h", ar_pins, c); end
    tick();
    checks++; if (ar_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%0b exp=0", ar_done); end
    checks++; if (ar_idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%0b exp=1", ar_idle); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    awready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      aw_req = mk(4'(i), 32'h100 + 32'(i * 4), 8'd1, 3'd2, 2'd1, 1'b0, 4'h3, 3'd2, 4'h1, 4'h0);
      aw_req_valid = 1'b1;
      if (aw_req_ready) accepted++;
      tick();
    end
    aw_req_valid = 1'b0;
    checks++; if (accepted != 5) begin errors++; $display("FAIL bp_accepted got=%0d exp=5", accepted); end
    checks++; if (aw_req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%0b exp=0", aw_req_ready); end
    checks++; if (aw_idle !== 1'b0) begin errors++; $display("FAIL bp_idle got=%0b exp=0", aw_idle); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (awvalid !== 1'b1 || awaddr !== 32'h100 || awid !== 4'd0)
        begin errors++; $display("FAIL bp_stable got=v%0b/%h exp=v1/100", awvalid, awaddr); end
      tick();
    end
    awready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (awvalid !== 1'b1 || awaddr !== 32'h100 + 32'(k * 4) || awcache !== 4'h3)
        begin errors++; $display("FAIL bp_order got=v%0b/%h exp=v1/%h", awvalid, awaddr, 32'h100 + 32'(k * 4)); end
      tick();
      checks++; if (aw_done !== 1'b1) begin errors++; $display("FAIL bp_done got=%0b exp=1", aw_done); end
    end
    checks++; if (awvalid !== 1'b0 || aw_idle !== 1'b1)
      begin errors++; $display("FAIL bp_drain got=v%0b/i%0b exp=v0/i1", awvalid, aw_idle); end
    checks++; if (awaddr !== 32'h110) begin errors++; $display("FAIL bp_fields_hold got=%h exp=110", awaddr); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    arready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        ar_req = b2b_cmd(t); ar_req_valid = 1'b1;
        checks++; if (ar_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready t=%0d got=0 exp=1", t); end
      end else begin
        ar_req_valid = 1'b0;
      end
      tick();
      if (ar_done) dones++;
      if (t >= 1 && t <= 8) begin
        checks++; if (arvalid !== 1'b1 || ar_pins !== b2b_cmd(t - 1))
          begin errors++; $display("FAIL b2b_cmd t=%0d got=v%0b/%h exp=v1/%h", t, arvalid, ar_pins, b2b_cmd(t - 1)); end
      end
      if (t >= 2) begin
        checks++; if (ar_done !== 1'b1) begin errors++; $display("FAIL b2b_done t=%0d got=0 exp=1", t); end
      end
    end
    checks++; if (dones != 8) begin errors++; $display("FAIL b2b_done_count got=%0d exp=8", dones); end
    checks++; if (arvalid !== 1'b0 || ar_idle !== 1'b1)
      begin errors++; $display("FAIL b2b_idle got=v%0b/i%0b exp=v0/i1", arvalid, ar_idle); end
  endtask

  task automatic test_independence();
    logic [CMD_W-1:0] awc;
    int dones = 0;
    awc = mk(4'hA, 32'h300, 8'd7, 3'd3, 2'd2, 1'b1, 4'h5, 3'd4, 4'h6, 4'h7);
    awready = 1'b0; arready = 1'b1;
    aw_req = awc; aw_req_valid = 1'b1;
    tick();
    aw_req_valid = 1'b0;
    tick();
    for (int t = 0; t < 6; t++) begin
      if (t < 3) begin
        ar_req = mk(4'(t + 1), 32'h5000 + 32'(t * 16), 8'd0, 3'd2, 2'd1, 1'b0, 4'h0, 3'd0, 4'h0, 4'h0);
        ar_req_valid = 1'b1;
      end else begin
        ar_req_valid = 1'b0;
      end
      tick();
      if (ar_done) dones++;
      checks++; if (awvalid !== 1'b1 || aw_pins !== awc || aw_done !== 1'b0)
        begin errors++; $display("FAIL indep_aw_hold t=%0d got=v%0b/%h exp=v1/%h", t, awvalid, aw_pins, awc); end
    end
    checks++; if (dones != 3) begin errors++; $display("FAIL indep_ar_dones got=%0d exp=3", dones); end
    checks++; if (ar_idle !== 1'b1 || araddr !== 32'h5020)
      begin errors++; $display("FAIL indep_ar_last got=i%0b/%h exp=i1/5020", ar_idle, araddr); end
    awready = 1'b1;
    tick();
    checks++; if (aw_done !== 1'b1 || awvalid !== 1'b0)
      begin errors++; $display("FAIL indep_aw_release got=d%0b/v%0b exp=d1/v0", aw_done, awvalid); end
  endtask

  task automatic test_mid_reset();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ar_req = mk(4'(i + 8), 32'h7000 + 32'(i * 4), 8'd0, 3'd2, 2'd1, 1'b0, 4'h0, 3'd0, 4'h0, 4'h0);
      ar_req_valid = 1'b1;
      tick();
    end
    ar_req_valid = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h7000)
      begin errors++; $display("FAIL mrst_pre got=v%0b/%h exp=v1/7000", arvalid, araddr); end
    #3 rst = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL mrst_async_valid got=%0b exp=0", arvalid); end
    checks++; if (ar_idle !== 1'b1 || ar_req_ready !== 1'b0)
      begin errors++; $display("FAIL mrst_async_state got=i%0b/r%0b exp=i1/r0", ar_idle, ar_req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (arvalid !== 1'b0 || ar_done !== 1'b0 || ar_idle !== 1'b1)
        begin errors++; $display("FAIL mrst_stale k=%0d got=v%0b/d%0b/i%0b exp=v0/d0/i1", k, arvalid, ar_done, ar_idle); end
    end
    ar_req = mk(4'd5, 32'h400, 8'd0, 3'd2, 2'd1, 1'b0, 4'h0, 3'd0, 4'h0, 4'h0);
    ar_req_valid = 1'b1;
    tick();
    ar_req_valid = 1'b0;
    tick();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h400 || arid !== 4'd5)
      begin errors++; $display("FAIL mrst_fresh got=v%0b/%h exp=v1/400", arvalid, araddr); end
    tick();
    checks++; if (ar_done !== 1'b1 || ar_idle !== 1'b1)
      begin errors++; $display("FAIL mrst_fresh_done got=d%0b/i%0b exp=d1/i1", ar_done, ar_idle); end
  endtask

  initial begin
    rst = 1'b1;
    ar_req_valid = 1'b0; aw_req_valid = 1'b0;
    ar_req = '0; aw_req = '0;
    arready = 1'b0; awready = 1'b0;
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_independence();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
